spi_cmd_master: RTL and testbench

//  SPI initiator for the pin expander's command protocol. Accepts a {command, data} byte pair
//  on a valid/ready handshake and sends it as two 8-bit SPI transfers, MSB first.

---
 rtl/spi_cmd_master.sv | 215 +++++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI initiator for the pin expander command protocol: sends a {command, data} byte pair
// as two MSB-first 8-bit transfers, each in its own active-high slave-select window.
module spi_cmd_master #(
  parameter int CLK_DIV = 5,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        ss,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [3:0]       bit_r, bit_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic             byte_r, byte_s;
  logic [15:0]      tx_r, tx_s;
  logic [15:0]      rx_r, rx_s;
  logic             ss_r, ss_s;
  logic             sclk_r, sclk_s;
  logic             mosi_r, mosi_s;
  logic             busy_r, busy_s;
  logic             ready_r, ready_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic [15:0]      rsp_data_r, rsp_data_s;
  logic [15:0]      tx_shift_s;
  logic [15:0]      rx_shift_s;

  // Every SCLK rise launches the next tx bit and samples miso in one step.
  assign tx_shift_s = {tx_r[14:0], 1'b0};
  assign rx_shift_s = {rx_r[14:0], miso};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    bit_s       = bit_r;
    gap_s       = gap_r;
    byte_s      = byte_r;
    tx_s        = tx_r;
    rx_s        = rx_r;
    ss_s        = ss_r;
    sclk_s      = sclk_r;
    mosi_s      = mosi_r;
    busy_s      = busy_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    case (state_r)
      IDLE, DONE: begin
        if (req_valid) begin
          state_s = LEAD;
          tx_s    = {req_cmd, req_data};
          rx_s    = 16'h0000;
          byte_s  = 1'b0;
          div_s   = DIV_ZERO;
          ss_s    = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      LEAD: begin
        if (div_r == DIV_LAST) begin
          state_s = SHIFT;
          div_s   = DIV_ZERO;
          bit_s   = 4'd0;
          sclk_s  = 1'b1;
          mosi_s  = tx_r[15];
          tx_s    = tx_shift_s;
          rx_s    = rx_shift_s;
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s = DIV_ZERO;
          if (bit_r == 4'd15) begin
            state_s = TRAIL;
          end else begin
            bit_s  = bit_r + 4'd1;
            sclk_s = ~sclk_r;
            // Only the rising half-periods move data; falls belong to the slave.
            if (!sclk_r) begin
              mosi_s = tx_r[15];
              tx_s   = tx_shift_s;
              rx_s   = rx_shift_s;
            end else begin
              mosi_s = mosi_r;
            end
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      TRAIL: begin
        if (div_r == DIV_LAST) begin
          state_s = GAP;
          div_s   = DIV_ZERO;
          gap_s   = GAP_ZERO;
          ss_s    = 1'b0;
          mosi_s  = 1'b0;
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_s = GAP_ZERO;
          if (!byte_r) begin
            state_s = LEAD;
            byte_s  = 1'b1;
            ss_s    = 1'b1;
          end else begin
            state_s     = DONE;
            rsp_valid_s = 1'b1;
            rsp_data_s  = rx_r;
            busy_s      = 1'b0;
          end
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        ss_s    = 1'b0;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
    // DONE accepts like IDLE so back-to-back frames lose no cycle.
    ready_s = (state_s == IDLE) || (state_s == DONE);
  end

  // Datapath, counters and registered pin/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r       <= DIV_ZERO;
      bit_r       <= 4'd0;
      gap_r       <= GAP_ZERO;
      byte_r      <= 1'b0;
      tx_r        <= 16'h0000;
      rx_r        <= 16'h0000;
      ss_r        <= 1'b0;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'h0000;
    end else begin
      div_r       <= div_s;
      bit_r       <= bit_s;
      gap_r       <= gap_s;
      byte_r      <= byte_s;
      tx_r        <= tx_s;
      rx_r        <= rx_s;
      ss_r        <= ss_s;
      sclk_r      <= sclk_s;
      mosi_r      <= mosi_s;
      busy_r      <= busy_s;
      ready_r     <= ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;
  assign ss        = ss_r;
  assign sclk      = sclk_r;
  assign mosi      = mosi_r;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: default-timing instance plus a CLK_DIV=1/GAP_CYC=1
// instance, each driven against a behavioural SPI slave that replies with a given byte pair.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_cmd = 8'h00;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready, rsp_valid, busy, ss, sclk, mosi;
  logic        miso = 1'b0;
  logic [15:0] rsp_data;

  logic        req_valid2 = 1'b0;
  logic [7:0]  req_cmd2 = 8'h00;
  logic [7:0]  req_data2 = 8'h00;
  logic        req_ready2, rsp_valid2, busy2, ss2, sclk2, mosi2;
  logic        miso2 = 1'b0;
  logic [15:0] rsp_data2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  spi_cmd_master #(.CLK_DIV(5), .GAP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_cmd_master #(.CLK_DIV(1), .GAP_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_cmd(req_cmd2), .req_data(req_data2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .busy(busy2), .ss(ss2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and pin monitor for the default instance (sampled mid-cycle).
  logic [7:0] rep [0:1];
  logic [7:0] sh, cap;
  logic       ss_q = 1'b0, sclk_q = 1'b0;
  bit         bidx = 1'b0;
  int         nrise = 0, last_rise = 0;
  int         ss_rise_q[$], ss_fall_q[$], rise_cnt_q[$], per_q[$];
  logic [7:0] cap_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      bidx = 1'b0;
      nrise = 0;
    end else begin
      if (ss && !ss_q) begin
        ss_rise_q.push_back(cyc);
        sh = rep[bidx];
        miso = sh[7];
        nrise = 0;
      end
      if (ss && sclk && !sclk_q) begin
        if (nrise > 0) per_q.push_back(cyc - last_rise);
        last_rise = cyc;
        nrise++;
      end
      if (ss && !sclk && sclk_q) begin
        cap = {cap[6:0], mosi};
        sh = {sh[6:0], 1'b0};
        miso = sh[7];
      end
      if (!ss && ss_q) begin
        ss_fall_q.push_back(cyc);
        cap_q.push_back(cap);
        rise_cnt_q.push_back(nrise);
        bidx = ~bidx;
        miso = 1'b0;
      end
    end
    ss_q = ss;
    sclk_q = sclk;
  end

  // Slave model and pin monitor for the fast instance.
  logic [7:0] rep2 [0:1];
  logic [7:0] sh2, cap2;
  logic       ss2_q = 1'b0, sclk2_q = 1'b0;
  bit         bidx2 = 1'b0;
  int         ss2_rise = 0, nrise2 = 0, last_rise2 = 0;
  int         len2_q[$], rise2_q[$], per2_q[$];
  logic [7:0] cap2_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      bidx2 = 1'b0;
    end else begin
      if (ss2 && !ss2_q) begin
        ss2_rise = cyc;
        sh2 = rep2[bidx2];
        miso2 = sh2[7];
        nrise2 = 0;
      end
      if (ss2 && sclk2 && !sclk2_q) begin
        if (nrise2 > 0) per2_q.push_back(cyc - last_rise2);
        last_rise2 = cyc;
        nrise2++;
      end
      if (ss2 && !sclk2 && sclk2_q) begin
        cap2 = {cap2[6:0], mosi2};
        sh2 = {sh2[6:0], 1'b0};
        miso2 = sh2[7];
      end
      if (!ss2 && ss2_q) begin
        len2_q.push_back(cyc - ss2_rise);
        rise2_q.push_back(nrise2);
        cap2_q.push_back(cap2);
        bidx2 = ~bidx2;
        miso2 = 1'b0;
      end
    end
    ss2_q = ss2;
    sclk2_q = sclk2;
  end

  task automatic start_req(input logic [7:0] c, input logic [7:0] d, input bit hold, output int t0);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd = c;
    req_data = d;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept: req_ready=%b, required 1", req_ready);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int tr, output logic [15:0] d);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tr = cyc;
    d = rsp_data;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ss, sclk, mosi, rsp_valid, busy} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_pins: ss,sclk,mosi,rsp_valid,busy=%b, required 00000",
               {ss, sclk, mosi, rsp_valid, busy});
    end
    total++;
    if (rsp_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rsp_data: got %h, required 0000", rsp_data);
    end
    total++;
    if ({ss2, sclk2, mosi2, rsp_valid2, busy2} !== 5'b00000 || rsp_data2 !== 16'h0000) begin
      bad++;
      $display("FAIL reset_fast: pins=%b data=%h, required 00000/0000",
               {ss2, sclk2, mosi2, rsp_valid2, busy2}, rsp_data2);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || req_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b/%b, required 1/1", req_ready, req_ready2);
    end
  endtask

  task automatic test_reset_cmd;
    int i0, t0, tr;
    logic [15:0] d;
    rep[0] = 8'hA5;
    rep[1] = 8'h3C;
    i0 = cap_q.size();
    start_req(8'h80, 8'h00, 1'b0, t0);
    wait_rsp(tr, d);
    total++;
    if (tr - t0 !== 189) begin
      bad++;
      $display("FAIL cmd_latency: got %0d, required 189", tr - t0);
    end
    total++;
    if (d !== 16'hA53C) begin
      bad++;
      $display("FAIL cmd_rsp_data: got %h, required a53c", d);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_in_rsp_cycle: got %b, required 0", busy);
    end
    total++;
    if (cap_q.size() !== i0 + 2) begin
      bad++;
      $display("FAIL cmd_byte_count: got %0d, required 2", cap_q.size() - i0);
    end else begin
      total++;
      if (cap_q[i0] !== 8'h80 || cap_q[i0+1] !== 8'h00) begin
        bad++;
        $display("FAIL cmd_mosi: got %h %h, required 80 00", cap_q[i0], cap_q[i0+1]);
      end
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_pulse_width: rsp_valid=%b one cycle later, required 0", rsp_valid);
    end
  endtask

  task automatic test_frame_timing;
    int r0, f0, c0, p0, i0, t0, tr;
    logic [15:0] d;
    rep[0] = 8'h55;
    rep[1] = 8'hF0;
    r0 = ss_rise_q.size();
    f0 = ss_fall_q.size();
    c0 = rise_cnt_q.size();
    p0 = per_q.size();
    i0 = cap_q.size();
    start_req(8'h9B, 8'hAA, 1'b0, t0);
    total++;
    if (busy !== 1'b1 || ss !== 1'b1) begin
      bad++;
      $display("FAIL first_cycle: busy=%b ss=%b, required 1 1", busy, ss);
    end
    wait_rsp(tr, d);
    total++;
    if (d !== 16'h55F0 || tr - t0 !== 189) begin
      bad++;
      $display("FAIL gpio_rsp: data=%h at %0d, required 55f0 at 189", d, tr - t0);
    end
    total++;
    if (ss_rise_q.size() !== r0 + 2 || ss_fall_q.size() !== f0 + 2 || cap_q.size() !== i0 + 2) begin
      bad++;
      $display("FAIL gpio_windows: rises=%0d falls=%0d, required 2 2",
               ss_rise_q.size() - r0, ss_fall_q.size() - f0);
    end else begin
      total++;
      if (ss_rise_q[r0] - t0 !== 1) begin
        bad++;
        $display("FAIL ss_rise_delay: got %0d, required 1", ss_rise_q[r0] - t0);
      end
      total++;
      if (ss_fall_q[f0] - ss_rise_q[r0] !== 90 || ss_fall_q[f0+1] - ss_rise_q[r0+1] !== 90) begin
        bad++;
        $display("FAIL ss_high: got %0d/%0d, required 90/90",
                 ss_fall_q[f0] - ss_rise_q[r0], ss_fall_q[f0+1] - ss_rise_q[r0+1]);
      end
      total++;
      if (ss_rise_q[r0+1] - ss_fall_q[f0] !== 4) begin
        bad++;
        $display("FAIL ss_gap: got %0d, required 4", ss_rise_q[r0+1] - ss_fall_q[f0]);
      end
      total++;
      if (rise_cnt_q[c0] !== 8 || rise_cnt_q[c0+1] !== 8) begin
        bad++;
        $display("FAIL sclk_rises: got %0d/%0d, required 8/8", rise_cnt_q[c0], rise_cnt_q[c0+1]);
      end
      total++;
      if (cap_q[i0] !== 8'h9B || cap_q[i0+1] !== 8'hAA) begin
        bad++;
        $display("FAIL gpio_mosi: got %h %h, required 9b aa", cap_q[i0], cap_q[i0+1]);
      end
    end
    total++;
    if (per_q.size() !== p0 + 14) begin
      bad++;
      $display("FAIL sclk_period_count: got %0d, required 14", per_q.size() - p0);
    end
    for (int k = p0; k < per_q.size(); k++) begin
      total++;
      if (per_q[k] !== 10) begin
        bad++;
        $display("FAIL sclk_period: got %0d, required 10", per_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int r0, f0, i0, t0, tr, tr2;
    logic [15:0] d1, d2;
    rep[0] = 8'h12;
    rep[1] = 8'h34;
    r0 = ss_rise_q.size();
    f0 = ss_fall_q.size();
    i0 = cap_q.size();
    start_req(8'h41, 8'h7E, 1'b1, t0);
    req_cmd = 8'h80;
    req_data = 8'h08;
    wait_rsp(tr, d1);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_in_rsp_cycle: got %b, required 1", req_ready);
    end
    total++;
    if (d1 !== 16'h1234 || tr - t0 !== 189) begin
      bad++;
      $display("FAIL b2b_first: data=%h at %0d, required 1234 at 189", d1, tr - t0);
    end
    rep[0] = 8'hC3;
    rep[1] = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || ss !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b ss=%b, required 1 1", busy, ss);
    end
    wait_rsp(tr2, d2);
    total++;
    if (d2 !== 16'hC35A || tr2 - tr !== 189) begin
      bad++;
      $display("FAIL b2b_second: data=%h at %0d, required c35a at 189", d2, tr2 - tr);
    end
    total++;
    if (ss_rise_q.size() !== r0 + 4 || ss_fall_q.size() !== f0 + 4 || cap_q.size() !== i0 + 4) begin
      bad++;
      $display("FAIL b2b_windows: rises=%0d, required 4", ss_rise_q.size() - r0);
    end else begin
      total++;
      if (ss_rise_q[r0+2] - ss_fall_q[f0+1] !== 5) begin
        bad++;
        $display("FAIL b2b_ss_low: got %0d, required 5", ss_rise_q[r0+2] - ss_fall_q[f0+1]);
      end
      total++;
      if ({cap_q[i0], cap_q[i0+1], cap_q[i0+2], cap_q[i0+3]} !== 32'h417E8008) begin
        bad++;
        $display("FAIL b2b_mosi: got %h %h %h %h, required 41 7e 80 08",
                 cap_q[i0], cap_q[i0+1], cap_q[i0+2], cap_q[i0+3]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int i0, t0, tr;
    bit seen;
    logic [15:0] d;
    rep[0] = 8'h00;
    rep[1] = 8'h00;
    start_req(8'h9B, 8'hFF, 1'b0, t0);
    while (cyc < t0 + 142) @(negedge clk);
    total++;
    if ({ss, sclk, mosi} !== 3'b111) begin
      bad++;
      $display("FAIL pre_abort_pins: ss,sclk,mosi=%b, required 111", {ss, sclk, mosi});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ss, sclk, mosi, busy, rsp_valid} !== 5'b00000 || rsp_data !== 16'h0000) begin
      bad++;
      $display("FAIL abort_pins: ss,sclk,mosi,busy,rsp_valid=%b data=%h, required 00000/0000",
               {ss, sclk, mosi, busy, rsp_valid}, rsp_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%b, required 0", seen);
    end
    rep[0] = 8'hE1;
    rep[1] = 8'h1E;
    i0 = cap_q.size();
    start_req(8'h80, 8'h00, 1'b0, t0);
    wait_rsp(tr, d);
    total++;
    if (d !== 16'hE11E || tr - t0 !== 189) begin
      bad++;
      $display("FAIL post_abort_rsp: data=%h at %0d, required e11e at 189", d, tr - t0);
    end
    total++;
    if (cap_q.size() !== i0 + 2) begin
      bad++;
      $display("FAIL post_abort_bytes: got %0d, required 2", cap_q.size() - i0);
    end else begin
      total++;
      if (cap_q[i0] !== 8'h80 || cap_q[i0+1] !== 8'h00) begin
        bad++;
        $display("FAIL post_abort_mosi: got %h %h, required 80 00", cap_q[i0], cap_q[i0+1]);
      end
    end
  endtask

  task automatic test_fast;
    int l0, p0, n, t0, tr;
    l0 = len2_q.size();
    p0 = per2_q.size();
    rep2[0] = 8'h69;
    rep2[1] = 8'h96;
    n = 0;
    @(negedge clk);
    req_valid2 = 1'b1;
    req_cmd2 = 8'hC5;
    req_data2 = 8'h3A;
    while (req_ready2 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    @(negedge clk);
    req_valid2 = 1'b0;
    n = 0;
    while (rsp_valid2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tr = cyc;
    total++;
    if (rsp_valid2 !== 1'b1 || tr - t0 !== 39) begin
      bad++;
      $display("FAIL fast_latency: rsp_valid=%b at %0d, required 1 at 39", rsp_valid2, tr - t0);
    end
    total++;
    if (rsp_data2 !== 16'h6996) begin
      bad++;
      $display("FAIL fast_rsp_data: got %h, required 6996", rsp_data2);
    end
    total++;
    if (len2_q.size() !== l0 + 2) begin
      bad++;
      $display("FAIL fast_windows: got %0d, required 2", len2_q.size() - l0);
    end else begin
      total++;
      if (len2_q[l0] !== 18 || len2_q[l0+1] !== 18) begin
        bad++;
        $display("FAIL fast_ss_high: got %0d/%0d, required 18/18", len2_q[l0], len2_q[l0+1]);
      end
      total++;
      if (rise2_q[l0] !== 8 || rise2_q[l0+1] !== 8) begin
        bad++;
        $display("FAIL fast_rises: got %0d/%0d, required 8/8", rise2_q[l0], rise2_q[l0+1]);
      end
      total++;
      if (cap2_q[l0] !== 8'hC5 || cap2_q[l0+1] !== 8'h3A) begin
        bad++;
        $display("FAIL fast_mosi: got %h %h, required c5 3a", cap2_q[l0], cap2_q[l0+1]);
      end
    end
    for (int k = p0; k < per2_q.size(); k++) begin
      total++;
      if (per2_q[k] !== 2) begin
        bad++;
        $display("FAIL fast_sclk_period: got %0d, required 2", per2_q[k]);
      end
    end
  endtask

  initial begin
    rep[0] = 8'h00;
    rep[1] = 8'h00;
    rep2[0] = 8'h00;
    rep2[1] = 8'h00;
    test_reset();
    test_reset_cmd();
    test_frame_timing();
    test_back_to_back();
    test_reset_mid_frame();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
